tlul_host_arb: RTL and testbench

- Round-robin arbiter that shares one TL-UL device port, typically the host side of a tlul_fifo_sync, between NumHosts TL-UL hosts.
- Grants A-channel requests and records the granted host index in an in-order ID FIFO.
- Routes each D-channel response back to the host at the head of that FIFO.
- The downstream device must respond in request order, as a tlul_fifo_sync-fronted TL-UL device does.

---
 rtl/tlul_host_arb.sv | 199 +++++++++++++++++++
 tb/tb_tlul_host_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one in-order TL-UL device port between NumHosts hosts.
// A-channel grants are tracked in an ID FIFO so D-channel responses route back to
// the host that issued the oldest outstanding request.
// Optional build macro: TLUL_HOST_ARB_STATS_EN adds per-host saturating grant counters.

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arb #(
    parameter int  NumHosts       = 3,
    parameter int  MaxOutstanding = 4,
    localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1,
    localparam int CntW = ((MaxOutstanding + 1) > 1) ? $clog2(MaxOutstanding + 1) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  tlul_pkg::tl_h2d_t [NumHosts-1:0]  tl_h_i,
    output tlul_pkg::tl_d2h_t [NumHosts-1:0]  tl_h_o,
    output tlul_pkg::tl_h2d_t                 tl_d_o,
    input  tlul_pkg::tl_d2h_t                 tl_d_i,
    output logic [CntW-1:0]                   outstanding_o,
    output logic [NumHosts-1:0]               gnt_o,
    output logic                              err_o
`ifdef TLUL_HOST_ARB_STATS_EN
    ,
    output logic [16*NumHosts-1:0]            grant_cnt_o
`endif
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [IdxW-1:0] fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] win_idx, cand, head_idx;
    logic            win_valid;
    logic            fifo_full, fifo_empty;
    logic            a_hs, d_hs, push, pop, drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign head_idx   = fifo_q[rptr_q];
    assign win_valid  = tl_h_i[win_idx].a_valid;

    // Winner select: a locked host keeps the grant, otherwise first valid from the RR pointer.
    always_comb begin
        win_idx = rr_q;
        cand    = '0;
        if (lock_q) begin
            win_idx = lock_idx_q;
        end else begin
            // Walk offsets high to low so the smallest offset from rr_q is the last to land.
            for (int k = NumHosts - 1; k >= 0; k--) begin
                cand = IdxW'((int'(rr_q) + k) % NumHosts);
                if (tl_h_i[cand].a_valid) win_idx = cand;
            end
        end
    end

    // Device-side request mux and response ready; an empty FIFO sinks stray responses.
    always_comb begin
        tl_d_o         = tl_h_i[win_idx];
        tl_d_o.a_valid = win_valid & ~fifo_full & ~rst_i;
        tl_d_o.d_ready = ~rst_i & (fifo_empty | tl_h_i[head_idx].d_ready);
    end

    assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_hs = tl_d_i.d_valid & tl_d_o.d_ready;
    assign push = a_hs;
    assign pop  = d_hs & ~fifo_empty;
    assign drop = d_hs & fifo_empty;

    // Host-side fan-out: D fields broadcast, valid/ready qualified per host.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].d_valid = ~rst_i & ~fifo_empty & (head_idx == IdxW'(i)) & tl_d_i.d_valid;
            tl_h_o[i].a_ready = ~rst_i & (win_idx == IdxW'(i)) & tl_d_i.a_ready & ~fifo_full;
            gnt_o[i]          = ~rst_i & win_valid & (win_idx == IdxW'(i));
        end
    end

    // Next-state for pointer, lock, ID FIFO, occupancy and error flag.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = win_valid & ~a_hs;
        lock_idx_d = win_idx;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q | drop;
        if (a_hs) begin
            rr_d = (win_idx == IdxW'(NumHosts - 1)) ? '0 : win_idx + 1'b1;
        end
        if (push) begin
            fifo_d[wptr_q] = win_idx;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset drops all in-flight tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

`ifdef TLUL_HOST_ARB_STATS_EN
    logic [NumHosts-1:0][15:0] gcnt_q, gcnt_d;

    // Per-host A-handshake counters, saturating at all-ones.
    always_comb begin
        for (int h = 0; h < NumHosts; h++) begin
            gcnt_d[h] = gcnt_q[h];
            if (a_hs && (win_idx == IdxW'(h)) && (gcnt_q[h] != 16'hFFFF)) begin
                gcnt_d[h] = gcnt_q[h] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) gcnt_q <= '0;
        else       gcnt_q <= gcnt_d;
    end

    assign grant_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb: expected A grants and D routes go into queues,
// a negedge monitor pops and compares on every handshake.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int NH = 3;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst;
    tl_h2d_t [NH-1:0] tl_h_i;
    tl_d2h_t [NH-1:0] tl_h_o;
    tl_h2d_t          tl_d_o;
    tl_d2h_t          tl_d_i;
    logic [2:0]       outstanding;
    logic [NH-1:0]    gnt;
    logic             err;
`ifdef TLUL_HOST_ARB_STATS_EN
    logic [16*NH-1:0] grant_cnt;
`endif

    tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tl_h_i        (tl_h_i),
        .tl_h_o        (tl_h_o),
        .tl_d_o        (tl_d_o),
        .tl_d_i        (tl_d_i),
        .outstanding_o (outstanding),
        .gnt_o         (gnt),
        .err_o         (err)
`ifdef TLUL_HOST_ARB_STATS_EN
        ,
        .grant_cnt_o   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [NH-1:0] gnt; logic [31:0] addr; } a_exp_t;
    typedef struct { int host; logic [31:0] data; } d_exp_t;
    a_exp_t exp_a[$];
    d_exp_t exp_d[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int h, input logic v, input logic [31:0] addr);
        tl_h_i[h].a_valid   = v;
        tl_h_i[h].a_address = addr;
        tl_h_i[h].a_opcode  = 3'h4;
    endtask

    task automatic rsp(input logic v, input logic [31:0] data);
        tl_d_i.d_valid  = v;
        tl_d_i.d_data   = data;
        tl_d_i.d_opcode = 3'h1;
    endtask

    task automatic push_a(input int h, input logic [31:0] addr);
        a_exp_t e;
        e.gnt  = NH'(1) << h;
        e.addr = addr;
        exp_a.push_back(e);
    endtask

    task automatic push_d(input int h, input logic [31:0] data);
        d_exp_t e;
        e.host = h;
        e.data = data;
        exp_d.push_back(e);
    endtask

    // Monitor: every A and D handshake consumes one expected entry.
    always @(negedge clk) begin
        a_exp_t ea;
        d_exp_t ed;
        if (!rst) begin
            if (tl_d_o.a_valid && tl_d_i.a_ready) begin
                if (exp_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected: grant %0b with no expected request at %0t", gnt, $time);
                end else begin
                    ea = exp_a.pop_front();
                    check("a_gnt", gnt, ea.gnt);
                    check("a_addr", tl_d_o.a_address, ea.addr);
                end
            end
            for (int i = 0; i < NH; i++) begin
                if (tl_h_o[i].d_valid && tl_h_i[i].d_ready) begin
                    if (exp_d.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL d_unexpected: host %0d got d_valid with no expected response at %0t", i, $time);
                    end else begin
                        ed = exp_d.pop_front();
                        check("d_host", i, ed.host);
                        check("d_data", tl_h_o[i].d_data, ed.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1);
    end

    initial begin
        int drain_host [3];
        tl_h_i = '0;
        for (int i = 0; i < NH; i++) tl_h_i[i].d_ready = 1'b1;
        tl_d_i = '0;
        rst    = 1'b1;

        // Reset: requests and responses present, everything forced quiet.
        req(0, 1'b1, 32'h10);
        tl_d_i.a_ready = 1'b1;
        rsp(1'b1, 32'h55);
        step(); step();
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_avalid", tl_d_o.a_valid, 0);
        check("rst_dready", tl_d_o.d_ready, 0);
        check("rst_aready", tl_h_o[0].a_ready, 0);
        check("rst_dvalid", tl_h_o[0].d_valid, 0);
        req(0, 1'b0, 0);
        rsp(1'b0, 0);
        rst = 1'b0;
        step();
        @(negedge clk);
        check("rst_out", outstanding, 0);
        check("rst_err", err, 0);
        check("rst_gnt_idle", gnt, 0);
        step();

        // Single host Get with response one cycle later.
        req(0, 1'b1, 32'h100);
        push_a(0, 32'h100);
        @(negedge clk);
        check("t1_gnt", gnt, 3'b001);
        check("t1_out0", outstanding, 0);
        step();
        req(0, 1'b0, 0);
        rsp(1'b1, 32'hD0);
        push_d(0, 32'hD0);
        @(negedge clk);
        check("t1_out1", outstanding, 1);
        check("t1_dvalid", tl_h_o[0].d_valid, 1);
        step();
        rsp(1'b0, 0);
        @(negedge clk);
        check("t1_out2", outstanding, 0);
        check("t1_err", err, 0);
        step();

        // Fairness from a fresh pointer: all hosts valid, responses trail by one cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int h = 0; h < NH; h++) req(h, 1'b1, 32'h200 + h);
        for (int c = 0; c <= 6; c++) begin
            if (c < 6) push_a(c % 3, 32'h200 + c % 3);
            if (c >= 1) begin
                rsp(1'b1, 32'hA0 + c);
                push_d((c - 1) % 3, 32'hA0 + c);
            end
            if (c == 6) for (int h = 0; h < NH; h++) req(h, 1'b0, 0);
            @(negedge clk);
            if (c < 6) check("t2_gnt", gnt, NH'(1) << (c % 3));
            check("t2_out", outstanding, (c == 0) ? 0 : 1);
            step();
        end
        rsp(1'b0, 0);
        @(negedge clk);
        check("t2_out_end", outstanding, 0);
        check("t2_err", err, 0);
        step();

        // Back-pressure lock on host1 while host0 also requests.
        tl_d_i.a_ready = 1'b0;
        req(1, 1'b1, 32'h310);
        @(negedge clk);
        check("t3_gnt0", gnt, 3'b010);
        step();
        req(0, 1'b1, 32'h300);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("t3_gnt_lock", gnt, 3'b010);
            check("t3_addr_lock", tl_d_o.a_address, 32'h310);
            check("t3_h0_aready", tl_h_o[0].a_ready, 0);
            step();
        end
        tl_d_i.a_ready = 1'b1;
        push_a(1, 32'h310);
        @(negedge clk);
        check("t3_gnt_hs", gnt, 3'b010);
        step();
        req(1, 1'b0, 0);
        req(2, 1'b1, 32'h320);
        push_a(2, 32'h320);
        @(negedge clk);
        check("t3_gnt_next", gnt, 3'b100);
        step();
        req(2, 1'b0, 0);
        push_a(0, 32'h300);
        @(negedge clk);
        check("t3_gnt_h0", gnt, 3'b001);
        step();
        req(0, 1'b0, 0);
        drain_host = '{1, 2, 0};
        for (int k = 0; k < 3; k++) begin
            rsp(1'b1, 32'hB0 + k);
            push_d(drain_host[k], 32'hB0 + k);
            @(negedge clk);
            check("t3_out_drain", outstanding, 3 - k);
            step();
        end
        rsp(1'b0, 0);

        // FIFO full: four accepted, fifth held until a response pops.
        req(0, 1'b1, 32'h400);
        for (int c = 0; c < 4; c++) begin
            push_a(0, 32'h400);
            @(negedge clk);
            check("t4_out_fill", outstanding, c);
            step();
        end
        @(negedge clk);
        check("t4_out_full", outstanding, 4);
        check("t4_avalid_full", tl_d_o.a_valid, 0);
        check("t4_aready_full", {tl_h_o[2].a_ready, tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 0);
        step();
        rsp(1'b1, 32'hC0);
        push_d(0, 32'hC0);
        @(negedge clk);
        check("t4_avalid_pop", tl_d_o.a_valid, 0);
        step();
        rsp(1'b0, 0);
        push_a(0, 32'h400);
        @(negedge clk);
        check("t4_out_after_pop", outstanding, 3);
        check("t4_avalid_resume", tl_d_o.a_valid, 1);
        step();
        req(0, 1'b0, 0);
        @(negedge clk);
        check("t4_out_refill", outstanding, 4);
        step();
        for (int k = 0; k < 4; k++) begin
            rsp(1'b1, 32'hC1 + k);
            push_d(0, 32'hC1 + k);
            step();
        end
        rsp(1'b0, 0);
        @(negedge clk);
        check("t4_out_end", outstanding, 0);
        step();

        // Routing: host2 then host0; first response overlaps a host1 request.
        req(2, 1'b1, 32'h520);
        push_a(2, 32'h520);
        @(negedge clk);
        check("t5_gnt_h2", gnt, 3'b100);
        step();
        req(2, 1'b0, 0);
        req(0, 1'b1, 32'h500);
        push_a(0, 32'h500);
        @(negedge clk);
        check("t5_gnt_h0", gnt, 3'b001);
        step();
        req(0, 1'b0, 0);
        req(1, 1'b1, 32'h510);
        push_a(1, 32'h510);
        rsp(1'b1, 32'hE0);
        push_d(2, 32'hE0);
        @(negedge clk);
        check("t5_out_pre", outstanding, 2);
        check("t5_dvalid_vec", {tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}, 3'b100);
        check("t5_gnt_h1", gnt, 3'b010);
        step();
        req(1, 1'b0, 0);
        rsp(1'b1, 32'hE1);
        push_d(0, 32'hE1);
        @(negedge clk);
        check("t5_out_same", outstanding, 2);
        check("t5_dvalid_h0", {tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}, 3'b001);
        step();
        rsp(1'b1, 32'hE2);
        push_d(1, 32'hE2);
        @(negedge clk);
        check("t5_out_dec", outstanding, 1);
        step();
        rsp(1'b0, 0);
        @(negedge clk);
        check("t5_out_end", outstanding, 0);
        step();

        // Stray response with empty FIFO, then reset with two outstanding.
        rsp(1'b1, 32'hF0);
        @(negedge clk);
        check("t6_dready_empty", tl_d_o.d_ready, 1);
        check("t6_dvalid_none", {tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}, 0);
        check("t6_err_pre", err, 0);
        step();
        rsp(1'b0, 0);
        @(negedge clk);
        check("t6_err_set", err, 1);
        step();
        @(negedge clk);
        check("t6_err_held", err, 1);
        step();
        req(0, 1'b1, 32'h600);
        push_a(0, 32'h600);
        step();
        push_a(0, 32'h600);
        step();
        req(0, 1'b0, 0);
        @(negedge clk);
        check("t6_out_two", outstanding, 2);
        check("t6_err_still", err, 1);
        rst = 1'b1;
        req(0, 1'b1, 32'h610);
        @(negedge clk);
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_avalid", tl_d_o.a_valid, 0);
        step();
        req(0, 1'b0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_rst", outstanding, 0);
        check("t6_err_rst", err, 0);
        check("t6_gnt_rst", gnt, 0);
        step();

        check("exp_a_drained", exp_a.size(), 0);
        check("exp_d_drained", exp_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
